// File: rtl/std_div_pipe.sv
// rtl/std_div_pipe.sv - iterative restoring divider, one quotient bit per cycle
// Optional signed mode: define STD_DIV_PIPE_SIGNED_EN.
module std_div_pipe #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] left,
  input  logic [width-1:0] right,
  input  logic             valid,
  output logic [width-1:0] out_quotient,
  output logic [width-1:0] out_remainder,
  output logic             ready,
  output logic             out_read_out,
  output logic             busy
);

  localparam int CW = $clog2(width + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [width-1:0] rem, dvd, dvs;
  logic [width:0]   shifted;
  logic             q_bit;
  logic [width-1:0] rem_nxt, quo_nxt;
  logic [width-1:0] mag_l, mag_r;
  logic [width-1:0] q_fix, r_fix;
  logic             accept;

  assign accept = valid && (state == IDLE || state == DONE);

`ifdef STD_DIV_PIPE_SIGNED_EN
  logic sign_l, sign_r;

  assign mag_l = left[width-1]  ? -left  : left;
  assign mag_r = right[width-1] ? -right : right;
  // Zero divisor bypasses the quotient sign fix so the result stays all ones;
  // negating the remainder magnitude by the dividend sign restores raw left.
  assign q_fix = (dvs == '0) ? '1 : ((sign_l ^ sign_r) ? -quo_nxt : quo_nxt);
  assign r_fix = sign_l ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_l <= 1'b0;
      sign_r <= 1'b0;
    end else if (accept) begin
      sign_l <= left[width-1];
      sign_r <= right[width-1];
    end
  end
`else
  assign mag_l = left;
  assign mag_r = right;
  assign q_fix = quo_nxt;
  assign r_fix = rem_nxt;
`endif

  // Restoring step: the extra top bit of shifted keeps the compare exact.
  always_comb begin
    shifted = {rem, dvd[width-1]};
    q_bit   = (shifted >= {1'b0, dvs});
    rem_nxt = q_bit ? width'(shifted - {1'b0, dvs}) : shifted[width-1:0];
    quo_nxt = {dvd[width-2:0], q_bit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid) state_nxt = RUN;
      RUN:     if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = valid ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready        = (state == DONE);
    out_read_out = (state == DONE);
    busy         = (state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem           <= '0;
      dvd           <= '0;
      dvs           <= '0;
      cnt           <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
    end else if (accept) begin
      rem <= '0;
      dvd <= mag_l;
      dvs <= mag_r;
      cnt <= CW'(width);
    end else if (state == RUN) begin
      rem <= rem_nxt;
      dvd <= quo_nxt;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        out_quotient  <= q_fix;
        out_remainder <= r_fix;
      end
    end
  end

endmodule

// File: tb/tb_std_div_pipe.sv
// tb/tb_std_div_pipe.sv - scoreboard bench for std_div_pipe at widths 8 and 32
module tb_std_div_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  left8 = '0, right8 = '0, q8, r8;
  logic        valid8 = 1'b0, ready8, rd8, busy8;
  logic [31:0] left32 = '0, right32 = '0, q32, r32;
  logic        valid32 = 1'b0, ready32, rd32, busy32;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [15:0] sb8[$];
  logic [63:0] sb32[$];

  always @(posedge clk) cyc <= cyc + 1;

  std_div_pipe #(.width(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .left(left8), .right(right8), .valid(valid8),
    .out_quotient(q8), .out_remainder(r8), .ready(ready8),
    .out_read_out(rd8), .busy(busy8)
  );

  std_div_pipe #(.width(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .left(left32), .right(right32), .valid(valid32),
    .out_quotient(q32), .out_remainder(r32), .ready(ready32),
    .out_read_out(rd32), .busy(busy32)
  );

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b);
    int ai, bi, q, r;
    if (b == 8'd0) return {8'hFF, a};
`ifdef STD_DIV_PIPE_SIGNED_EN
    ai = $signed(a);
    bi = $signed(b);
`else
    ai = int'(a);
    bi = int'(b);
`endif
    q = ai / bi;
    r = ai % bi;
    return {q[7:0], r[7:0]};
  endfunction

  function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b);
    longint ai, bi, q, r;
    if (b == 32'd0) return {32'hFFFFFFFF, a};
`ifdef STD_DIV_PIPE_SIGNED_EN
    ai = longint'($signed(a));
    bi = longint'($signed(b));
`else
    ai = longint'({32'd0, a});
    bi = longint'({32'd0, b});
`endif
    q = ai / bi;
    r = ai % bi;
    return {q[31:0], r[31:0]};
  endfunction

  task automatic start8(input logic [7:0] a, input logic [7:0] b, output int t0);
    left8 = a;
    right8 = b;
    valid8 = 1'b1;
    @(posedge clk);
    #1;
    valid8 = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait8(output int tr);
    tr = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready8) begin
        tr = cyc;
        break;
      end
    end
  endtask

  task automatic pop8(output logic [15:0] e);
    e = 16'hxxxx;
    if (sb8.size() > 0) e = sb8.pop_front();
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({q8, r8, ready8, rd8, busy8} !== 19'd0) begin
      failures++;
      $display("FAIL reset8 got q=%h r=%h rdy=%b rd=%b busy=%b want all 0", q8, r8, ready8, rd8, busy8);
    end
    checks++;
    if ({q32, r32, ready32, rd32, busy32} !== 67'd0) begin
      failures++;
      $display("FAIL reset32 got q=%h r=%h rdy=%b want all 0", q32, r32, ready32);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int t0, tr;
    logic [15:0] e;
    sb8.push_back(model8(8'd100, 8'd7));
    start8(8'd100, 8'd7, t0);
    checks++;
    if (busy8 !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy got %b want 1", busy8);
    end
    wait8(tr);
    pop8(e);
    checks++;
    if (tr < 0 || tr - t0 + 1 != 9) begin
      failures++;
      $display("FAIL basic_latency got %0d want 9", (tr < 0) ? -1 : tr - t0 + 1);
    end
    checks++;
    if ({q8, r8} !== e || rd8 !== 1'b1 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL basic_result got q=%0d r=%0d rd=%b busy=%b want q=%0d r=%0d rd=1 busy=0",
               q8, r8, rd8, busy8, e[15:8], e[7:0]);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ready8 !== 1'b0 || {q8, r8} !== e) begin
        failures++;
        $display("FAIL basic_hold got rdy=%b q=%0d r=%0d want rdy=0 q=%0d r=%0d",
                 ready8, q8, r8, e[15:8], e[7:0]);
      end
    end
  endtask

  task automatic test_div_zero;
    int t0, tr;
    logic [15:0] e;
    logic [7:0] a[2] = '{8'd37, 8'd255};
    logic [7:0] b[2] = '{8'd0, 8'd255};
    for (int k = 0; k < 2; k++) begin
      sb8.push_back(model8(a[k], b[k]));
      start8(a[k], b[k], t0);
      wait8(tr);
      pop8(e);
      checks++;
      if (tr < 0 || {q8, r8} !== e) begin
        failures++;
        $display("FAIL divzero_%0d got q=%h r=%h tr=%0d want q=%h r=%h", k, q8, r8, tr, e[15:8], e[7:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int t0, tr;
    logic [15:0] e;
    sb8.push_back(model8(8'd200, 8'd3));
    start8(8'd200, 8'd3, t0);
    @(posedge clk);
    #1;
    left8 = 8'd9;
    right8 = 8'd4;
    valid8 = 1'b1;
    @(posedge clk);
    #1 valid8 = 1'b0;
    wait8(tr);
    pop8(e);
    checks++;
    if (tr < 0 || tr - t0 + 1 != 9 || {q8, r8} !== e) begin
      failures++;
      $display("FAIL ignore_midrun got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=9",
               q8, r8, (tr < 0) ? -1 : tr - t0 + 1, e[15:8], e[7:0]);
    end
    sb8.push_back(model8(8'd9, 8'd4));
    start8(8'd9, 8'd4, t0);
    checks++;
    if (busy8 !== 1'b1 || {q8, r8} !== e) begin
      failures++;
      $display("FAIL b2b_accept got busy=%b q=%0d r=%0d want busy=1 held result", busy8, q8, r8);
    end
    wait8(tr);
    pop8(e);
    checks++;
    if (tr < 0 || tr - t0 + 1 != 9 || {q8, r8} !== e) begin
      failures++;
      $display("FAIL b2b_result got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=9",
               q8, r8, (tr < 0) ? -1 : tr - t0 + 1, e[15:8], e[7:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int t0, tr, seen;
    logic [15:0] e;
    start8(8'd250, 8'd5, t0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({q8, r8, ready8, rd8, busy8} !== 19'd0) begin
      failures++;
      $display("FAIL abort_outputs got q=%0d r=%0d rdy=%b rd=%b busy=%b want all 0", q8, r8, ready8, rd8, busy8);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ready8) seen++;
      if (i == 2) rst_n = 1'b1;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_no_ready got %0d pulses want 0", seen);
    end
    sb8.push_back(model8(8'd250, 8'd5));
    start8(8'd250, 8'd5, t0);
    wait8(tr);
    pop8(e);
    checks++;
    if (tr < 0 || {q8, r8} !== e) begin
      failures++;
      $display("FAIL after_abort got q=%0d r=%0d want q=%0d r=%0d", q8, r8, e[15:8], e[7:0]);
    end
  endtask

  task automatic test_random;
    int t0, tr;
    logic [15:0] e;
    logic [7:0] a, b;
    for (int k = 0; k < 8; k++) begin
      a = 8'($urandom_range(0, 255));
      b = (k == 0) ? 8'd1 : 8'($urandom_range(0, 255));
      sb8.push_back(model8(a, b));
      start8(a, b, t0);
      wait8(tr);
      pop8(e);
      checks++;
      if (tr < 0 || {q8, r8} !== e) begin
        failures++;
        $display("FAIL random_%0d %h/%h got q=%h r=%h want q=%h r=%h", k, a, b, q8, r8, e[15:8], e[7:0]);
      end
    end
  endtask

`ifdef STD_DIV_PIPE_SIGNED_EN
  task automatic test_signed;
    int t0, tr;
    logic [15:0] e;
    logic [7:0]  a[3] = '{8'hF9, 8'h07, 8'h80};
    logic [7:0]  b[3] = '{8'h02, 8'hFE, 8'hFF};
    logic [15:0] x[3] = '{16'hFDFF, 16'hFD01, 16'h8000};
    for (int k = 0; k < 3; k++) begin
      sb8.push_back(x[k]);
      start8(a[k], b[k], t0);
      wait8(tr);
      pop8(e);
      checks++;
      if (tr < 0 || tr - t0 + 1 != 9 || {q8, r8} !== e) begin
        failures++;
        $display("FAIL signed_%0d got q=%h r=%h want q=%h r=%h", k, q8, r8, e[15:8], e[7:0]);
      end
    end
  endtask
`endif

  task automatic test_wide;
    int t0, tr;
    logic [63:0] e;
    sb32.push_back(model32(32'hFFFFFFFF, 32'h10));
    left32 = 32'hFFFFFFFF;
    right32 = 32'h10;
    valid32 = 1'b1;
    @(posedge clk);
    #1 valid32 = 1'b0;
    t0 = cyc;
    tr = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (ready32) begin
        tr = cyc;
        break;
      end
    end
    e = (sb32.size() > 0) ? sb32.pop_front() : 64'hx;
    checks++;
    if (tr < 0 || tr - t0 + 1 != 33) begin
      failures++;
      $display("FAIL wide_latency got %0d want 33", (tr < 0) ? -1 : tr - t0 + 1);
    end
    checks++;
    if ({q32, r32} !== e) begin
      failures++;
      $display("FAIL wide_result got q=%h r=%h want q=%h r=%h", q32, r32, e[63:32], e[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_reset_abort();
    test_random();
`ifdef STD_DIV_PIPE_SIGNED_EN
    test_signed();
`endif
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/std_div_pipe.md
# std_div_pipe

Multi-cycle iterative divider for the std primitive library: a sequential successor to the single-cycle combinational `std_div`. It is parametrised in width and produces both quotient and remainder. It uses the library's `valid`/`ready` handshake and computes one quotient bit per cycle, so wide division no longer sits in a single combinational path. It is instantiated wherever generated designs need division at widths where a combinational divider fails timing.

## Interface
- `width`, default 32, operand and result width in bits (≥ 2).
- `clk  input  1  clock; all state updates on rising edge.`
- `rst_n  input  1  reset, asynchronous, active-low.`
- `left  input  width  dividend; sampled only on the accepting edge.`
- `right  input  width  divisor; sampled only on the accepting edge.`
- `valid  input  1  start request.`
- `out_quotient  output  width  quotient of the last completed division.`
- `out_remainder  output  width  remainder of the last completed division.`
- `ready  output  1  one-cycle completion pulse.`
- `out_read_out  output  1  equals `ready`; results are valid to read.`
- `busy  output  1  high while in RUN.`

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `valid`=1 at an edge latches `left` and `right`, clears the partial remainder and loads the iteration counter with `width`. Goes to RUN.
- RUN, one restoring step per edge:
  - Shift {rem, dividend} left by 1.
  - If rem ≥ divisor: rem −= divisor, and the shifted-in quotient bit = 1. Otherwise the bit = 0.
  - Decrement the counter. When the step taken with counter = 1 completes, write `out_quotient`/`out_remainder` and go to DONE.
- DONE:
  - `ready`=`out_read_out`=1 for exactly this cycle.
  - Next edge: goes to RUN if `valid`=1 (back-to-back accept, new operands latched), else IDLE.
- `valid` in RUN is ignored: no queueing and no restart.
- Result outputs change only on entry to DONE. They hold their values through IDLE and through a following RUN.
- Divide by zero: quotient = all ones, remainder = `left`. This falls out of the restoring algorithm; no special state is needed. It is still reported with the normal `ready` pulse.
- Internal datapath: rem is width+1 bits, so the compare/subtract cannot overflow. Outputs are the low `width` bits.

## Timing
- Reset (async assert): state = IDLE; `out_quotient`=0, `out_remainder`=0, `ready`=0, `out_read_out`=0, `busy`=0. Deassertion is synchronised by the user.
- With `valid` sampled high at edge E0:
  - `busy` is high from after E0 through after E(width−1).
  - `ready` is high in the single cycle after edge E(width).
  - Latency is width+1 cycles from the `valid` cycle to the `ready` cycle.
- Throughput is one division per width+1 cycles when back-to-back (accept in DONE).
- Reset asserted mid-RUN aborts immediately, with no `ready` pulse. Outputs return to 0.
- `ready` is never high in two consecutive cycles.

## Configuration
- `STD_DIV_PIPE_SIGNED_EN`
  - Defined (two's-complement signed operands and results):
    - The accepting edge latches operand magnitudes and the two sign bits.
    - Quotient is negated if the signs differ; remainder takes the dividend's sign (truncating division).
    - −2^(width−1) / −1 gives quotient −2^(width−1) and remainder 0 (wraps).
    - Divide by zero gives quotient all ones and remainder = `left` (raw).
    - Sign fix-up happens combinationally when results are written at DONE entry; latency is unchanged.
  - Undefined: unsigned only, with no sign logic.

## Test plan
- width=8, unsigned: `left`=100, `right`=7, `valid` for 1 cycle -> `ready` pulse exactly 9 cycles later; q=14, r=2; outputs hold afterwards.
- width=8: 37/0 -> q=255, r=37 with a normal `ready` pulse; then 255/255 -> q=1, r=0.
- width=8: start 200/3, pulse `valid` again mid-RUN with 9/4 -> the second request is ignored; q=66, r=2. Then assert `valid` in the DONE cycle with 9/4 -> next `ready` 9 cycles later, q=2, r=1.
- width=8: start 250/5, assert `rst_n`=0 at cycle 4 -> all outputs 0 immediately and no `ready` pulse. After release, 250/5 -> q=50, r=0.
- width=8, `STD_DIV_PIPE_SIGNED_EN` defined:
  - −7/2 -> q=0xFD (−3), r=0xFF (−1).
  - 7/−2 -> q=0xFD, r=1.
  - −128/−1 -> q=0x80, r=0.
- width=32: 0xFFFFFFFF/0x10 -> q=0x0FFFFFFF, r=0xF, with `ready` 33 cycles after `valid`.
